// File: rtl/mod_exp_ctrl.sv
// ---------------------------------------------------------------------------
// mod_exp_ctrl
//
// Sequencer for left-to-right square-and-multiply modular exponentiation.
// It walks the exponent from bit exp_len-1 down to bit 0 and drives a
// Montgomery product stage one operation at a time:
//   - square (op 0) for every bit,
//   - multiply (op 1) after the square when that bit is 1,
//   - one final normalize (op 2) after the last bit.
// Each operation starts with a one-cycle mp_start pulse. Completion is the
// rising edge of the product stage's mp_stop level.
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   reset       : synchronous, active-high reset
//   start       : request one exponentiation (only looked at when idle)
//   exp         : exponent, captured when start is accepted
//   exp_len     : number of exponent bits to process, 0..BITLEN
//                 (larger values are treated as BITLEN)
//   mp_start    : one-cycle start pulse to the product stage
//   mp_op_code  : 0 = square, 1 = multiply, 2 = normalize
//   mp_stop     : completion level from the product stage
//   busy        : high from the cycle after an accepted start until done
//   done        : one-cycle pulse after the normalize op completes
//   sq_count    : square ops issued in the current run
//   mul_count   : multiply ops issued in the current run
// ---------------------------------------------------------------------------
module mod_exp_ctrl #(
  parameter int BITLEN     = 256,
  parameter int LOG_BITLEN = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BITLEN-1:0]     exp,
  input  logic [LOG_BITLEN:0]   exp_len,
  output logic                  mp_start,
  output logic [1:0]            mp_op_code,
  input  logic                  mp_stop,
  output logic                  busy,
  output logic                  done,
  output logic [LOG_BITLEN:0]   sq_count,
  output logic [LOG_BITLEN:0]   mul_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FIN_ISSUE,
    S_FIN_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_SQUARE = 2'd0;
  localparam logic [1:0] OP_MULT   = 2'd1;
  localparam logic [1:0] OP_NORM   = 2'd2;

  localparam logic [LOG_BITLEN:0]   MAX_LEN = (LOG_BITLEN+1)'(BITLEN);
  localparam logic [LOG_BITLEN:0]   ONE_L   = (LOG_BITLEN+1)'(1);
  localparam logic [LOG_BITLEN-1:0] ONE_I   = LOG_BITLEN'(1);

  state_t                  state_q,      state_d;
  logic [BITLEN-1:0]       exp_q,        exp_d;
  logic [LOG_BITLEN-1:0]   idx_q,        idx_d;
  logic [1:0]              op_q,         op_d;
  logic                    mp_start_q,   mp_start_d;
  logic                    busy_q,       busy_d;
  logic                    done_q,       done_d;
  logic [LOG_BITLEN:0]     sq_q,         sq_d;
  logic [LOG_BITLEN:0]     mul_q,        mul_d;
  logic                    mp_stop_q,    mp_stop_d;

  logic [LOG_BITLEN:0]     len_eff;
  logic                    mp_done;

  // Oversized lengths saturate to the full exponent width.
  assign len_eff = (exp_len > MAX_LEN) ? MAX_LEN : exp_len;

  // Only a low-to-high transition of mp_stop means "finished"; a level left
  // high by the previous operation must not end the next one early.
  assign mp_done = mp_stop & ~mp_stop_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    exp_d      = exp_q;
    idx_d      = idx_q;
    op_d       = op_q;
    mp_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sq_d       = sq_q;
    mul_d      = mul_q;
    mp_stop_d  = mp_stop;

    unique case (state_q)
      S_IDLE: begin
        op_d = OP_SQUARE;
        if (start) begin
          exp_d      = exp;
          sq_d       = '0;
          mul_d      = '0;
          busy_d     = 1'b1;
          mp_start_d = 1'b1;
          if (len_eff == '0) begin
            idx_d   = '0;
            op_d    = OP_NORM;
            state_d = S_FIN_ISSUE;
          end else begin
            idx_d   = LOG_BITLEN'(len_eff - ONE_L);
            op_d    = OP_SQUARE;
            state_d = S_ISSUE;
          end
        end
      end

      // mp_start is high during this state; account for the op here.
      S_ISSUE: begin
        if (op_q == OP_MULT) begin
          mul_d = mul_q + ONE_L;
        end else begin
          sq_d = sq_q + ONE_L;
        end
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (mp_done) begin
          state_d = S_NEXT;
        end
      end

      // A square of a 1 bit is followed by a multiply on the same bit;
      // otherwise step to the next lower bit, or finish after bit 0.
      S_NEXT: begin
        mp_start_d = 1'b1;
        if (op_q == OP_SQUARE && exp_q[idx_q]) begin
          op_d    = OP_MULT;
          state_d = S_ISSUE;
        end else if (idx_q != '0) begin
          idx_d   = idx_q - ONE_I;
          op_d    = OP_SQUARE;
          state_d = S_ISSUE;
        end else begin
          op_d    = OP_NORM;
          state_d = S_FIN_ISSUE;
        end
      end

      S_FIN_ISSUE: begin
        state_d = S_FIN_WAIT;
      end

      S_FIN_WAIT: begin
        if (mp_done) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        op_d    = OP_SQUARE;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      op_q       <= OP_SQUARE;
      mp_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sq_q       <= '0;
      mul_q      <= '0;
      mp_stop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      mp_start_q <= mp_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sq_q       <= sq_d;
      mul_q      <= mul_d;
      mp_stop_q  <= mp_stop_d;
    end
  end

  // NOTE: the exponent copy is pure data that is always written on an
  // accepted start before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    exp_q <= exp_d;
  end

  assign mp_start   = mp_start_q;
  assign mp_op_code = op_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sq_count   = sq_q;
  assign mul_count  = mul_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mod_exp_ctrl
//
// Self-checking bench for mod_exp_ctrl. The expected op sequence and final
// counts of each run are derived from the exponent bits and pushed into
// queues when the run is launched; a monitor on the falling clock edge pops
// and compares them whenever the DUT pulses mp_start or done. A simple
// product-stage model answers every mp_start by dropping mp_stop after
// fall_delay cycles and raising it after rise_delay cycles.
// ---------------------------------------------------------------------------
module tb_mod_exp_ctrl;

  localparam int BITLEN     = 256;
  localparam int LOG_BITLEN = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [BITLEN-1:0]     exp_in = '0;
  logic [LOG_BITLEN:0]   exp_len = '0;
  logic                  mp_start;
  logic [1:0]            mp_op_code;
  logic                  mp_stop = 1'b0;
  logic                  busy;
  logic                  done;
  logic [LOG_BITLEN:0]   sq_count;
  logic [LOG_BITLEN:0]   mul_count;

  mod_exp_ctrl #(
    .BITLEN     (BITLEN),
    .LOG_BITLEN (LOG_BITLEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .exp        (exp_in),
    .exp_len    (exp_len),
    .mp_start   (mp_start),
    .mp_op_code (mp_op_code),
    .mp_stop    (mp_stop),
    .busy       (busy),
    .done       (done),
    .sq_count   (sq_count),
    .mul_count  (mul_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sq;
    int mul;
  } done_rec_t;

  int        ops_q[$];
  done_rec_t done_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Product-stage model and monitor state.
  int fall_delay = 1;
  int rise_delay = 6;
  bit outstanding = 1'b0;
  int cnt = -1;
  int since_rise = 0;
  bit first_op = 1'b1;
  int run_ops = 0;
  int last_code = 0;
  int exp_code;
  done_rec_t got_rec;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: square every processed bit from the top, multiply after each
  // 1 bit, then normalize once.
  task automatic expect_run(input logic [BITLEN-1:0] e, input int len);
    int n;
    done_rec_t rec;
    n = (len > BITLEN) ? BITLEN : len;
    rec.sq  = 0;
    rec.mul = 0;
    for (int i = n - 1; i >= 0; i--) begin
      ops_q.push_back(0);
      rec.sq++;
      if (e[i]) begin
        ops_q.push_back(1);
        rec.mul++;
      end
    end
    ops_q.push_back(2);
    done_q.push_back(rec);
  endtask

  function automatic logic [BITLEN-1:0] rand_exp();
    logic [BITLEN-1:0] e;
    for (int w = 0; w < BITLEN / 32; w++) begin
      e[w*32 +: 32] = $urandom;
    end
    return e;
  endfunction

  // Presents start for one cycle while idle, then scrambles exp/exp_len so
  // any late sampling by the DUT shows up as a wrong sequence.
  task automatic launch(input logic [BITLEN-1:0] e, input int len);
    @(negedge clk);
    start   = 1'b1;
    exp_in  = e;
    exp_len = (LOG_BITLEN+1)'(len);
    expect_run(e, len);
    first_op = 1'b1;
    run_ops  = 0;
    @(negedge clk);
    start   = 1'b0;
    exp_in  = rand_exp();
    exp_len = (LOG_BITLEN+1)'($urandom);
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", got, 1);
    @(negedge clk);
    check("idle_op_code", mp_op_code, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic run(input logic [BITLEN-1:0] e, input int len);
    launch(e, len);
    wait_done();
  endtask

  task automatic wait_ops(input int n);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (run_ops >= n) begin
        got = 1'b1;
        break;
      end
    end
    check("ops_reached", got, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mp_start"}, mp_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_op_code"}, mp_op_code, 0);
    check({tag, "_sq_count"}, sq_count, 0);
    check({tag, "_mul_count"}, mul_count, 0);
  endtask

  // Product-stage model plus scoreboard monitor, both on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      outstanding = 1'b0;
      cnt         = -1;
    end else begin
      since_rise++;
      if (mp_start) begin
        check("one_start_per_op", outstanding, 0);
        if (!first_op) begin
          check("issue_gap", since_rise, 2);
        end
        first_op = 1'b0;
        check("busy_during_op", busy, 1);
        check("start_expected", (ops_q.size() > 0) ? 1 : 0, 1);
        if (ops_q.size() > 0) begin
          exp_code = ops_q.pop_front();
          check("op_code", mp_op_code, exp_code);
        end
        last_code   = int'(mp_op_code);
        run_ops++;
        outstanding = 1'b1;
        cnt         = 0;
      end else begin
        if (busy || done) begin
          check("op_code_held", mp_op_code, last_code);
        end
        if (cnt >= 0) begin
          cnt++;
          if (cnt == fall_delay) begin
            mp_stop = 1'b0;
          end
          if (cnt == rise_delay) begin
            mp_stop     = 1'b1;
            outstanding = 1'b0;
            since_rise  = 0;
            cnt         = -1;
          end
        end
      end
      if (done) begin
        check("done_expected", (done_q.size() > 0) ? 1 : 0, 1);
        if (done_q.size() > 0) begin
          got_rec = done_q.pop_front();
          check("sq_count", sq_count, got_rec.sq);
          check("mul_count", mul_count, got_rec.mul);
          check("ops_left_at_done", ops_q.size(), 0);
          check("busy_at_done", busy, 0);
        end
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BITLEN-1:0] e;

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // Reference example: 1011 -> 0,1,0,0,1,0,1,2.
    run(BITLEN'(4'b1011), 4);

    // Zero-length exponent: only the normalize op.
    run(rand_exp(), 0);

    // Bits above exp_len are ignored.
    run({BITLEN{1'b1}}, 5);

    // Oversized length saturates to BITLEN.
    run(rand_exp(), 300);

    // Full-width all ones: 513 ops.
    run({BITLEN{1'b1}}, BITLEN);

    // mp_stop still high from the previous run and slow to fall: the high
    // level must not complete the first op.
    fall_delay = 3;
    rise_delay = 8;
    run(rand_exp(), 16);
    fall_delay = 1;
    rise_delay = 6;

    // start during WAIT with a different exponent is ignored.
    e = rand_exp();
    launch(e, 12);
    wait_ops(2);
    @(negedge clk);
    start   = 1'b1;
    exp_in  = ~e;
    exp_len = (LOG_BITLEN+1)'(20);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset during the third op's WAIT, with start also asserted.
    launch({BITLEN{1'b1}}, 10);
    wait_ops(3);
    @(negedge clk);
    reset  = 1'b1;
    start  = 1'b1;
    exp_in = rand_exp();
    ops_q.delete();
    done_q.delete();
    @(negedge clk);
    check_reset_values("mid_reset");
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_busy", busy, 0);
    run(rand_exp(), 9);

    // Randomized runs with varying product-stage latency.
    for (int r = 0; r < 12; r++) begin
      rise_delay = $urandom_range(2, 9);
      run(rand_exp(), $urandom_range(0, 48));
    end
    rise_delay = 6;

    check("ops_queue_drained", ops_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
